// File: rtl/rr_grant_encoder_pkg.sv
// rtl/rr_grant_encoder_pkg.sv - shared state encoding and index-width helper for rr_grant_encoder
package rr_grant_encoder_pkg;

    // Two-state grant FSM
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width for n lines: ceil(log2(n)), never less than 1
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_grant_encoder_prio_enc.sv
// rtl/rr_grant_encoder_prio_enc.sv - combinational lowest-set-bit finder
//
// Ports:
//   req       in   N      request vector, any number of bits set
//   idx       out  IDX_W  index of the lowest set bit (0 when none set)
//   any_valid out  1      at least one bit of req is set
module prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    // Scan from the top down so the lowest set bit is the last to overwrite idx
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = IDX_W'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// rtl/rr_grant_encoder.sv - N-way arbiter with registered, acknowledge-held grant
//
// Ports:
//   clk_in          in   1      clock, rising edge
//   rst_in          in   1      synchronous active-high reset
//   req_in          in   N      request vector
//   ack_in          in   1      granted requester is done; releases the grant
//   gnt_valid_out   out  1      a grant is held
//   gnt_idx_out     out  IDX_W  binary index of the granted line
//   gnt_onehot_out  out  N      one-hot grant, zero when not valid
module rr_grant_encoder
    import rr_grant_encoder_pkg::*;
#(
    parameter int N       = 4,
    parameter int IDX_W   = 2,
    parameter int RR_MODE = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [N-1:0]     req_in,
    input  logic             ack_in,
    output logic             gnt_valid_out,
    output logic [IDX_W-1:0] gnt_idx_out,
    output logic [N-1:0]     gnt_onehot_out
);

    state_t           state_q, state_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;

    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic [IDX_W-1:0] all_idx;
    logic             release_grant;

    assign release_grant = (state_q == GRANT) && ack_in;

    prio_enc #(.N(N), .IDX_W(IDX_W)) u_prio_all (
        .req       (req_in),
        .idx       (all_idx),
        .any_valid (win_any)
    );

    if (RR_MODE != 0) begin : g_rr
        logic [IDX_W-1:0] ptr_q, ptr_d;
        logic [N-1:0]     req_masked;
        logic [IDX_W-1:0] masked_idx;
        logic             masked_any;

        // Only lines at or above the pointer compete in the first pass
        always_comb begin
            req_masked = '0;
            for (int i = 0; i < N; i++) begin
                req_masked[i] = req_in[i] && (i >= int'(ptr_q));
            end
        end

        prio_enc #(.N(N), .IDX_W(IDX_W)) u_prio_masked (
            .req       (req_masked),
            .idx       (masked_idx),
            .any_valid (masked_any)
        );

        // Nothing at or above the pointer means wrap to the lowest requester
        assign win_idx = masked_any ? masked_idx : all_idx;

        // Pointer advances past the released winner; wrap is at N, not 2^IDX_W
        always_comb begin
            ptr_d = ptr_q;
            if (release_grant) begin
                if (gnt_idx_q == IDX_W'(N - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_idx_q + IDX_W'(1);
                end
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_fixed
        assign win_idx = all_idx;
    end

    always_comb begin
        state_d      = state_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d     = GRANT;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = win_idx;
                    for (int i = 0; i < N; i++) begin
                        gnt_onehot_d[i] = (win_idx == IDX_W'(i));
                    end
                end
            end
            GRANT: begin
                // Requests are ignored while held; ack always lands in IDLE first
                if (ack_in) begin
                    state_d      = IDLE;
                    gnt_valid_d  = 1'b0;
                    gnt_idx_d    = '0;
                    gnt_onehot_d = '0;
                end
            end
            default: begin
                state_d      = IDLE;
                gnt_valid_d  = 1'b0;
                gnt_idx_d    = '0;
                gnt_onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
        end
    end

    assign gnt_valid_out  = gnt_valid_q;
    assign gnt_idx_out    = gnt_idx_q;
    assign gnt_onehot_out = gnt_onehot_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb/tb_rr_grant_encoder.sv - self-checking bench for rr_grant_encoder (fixed N=4, RR N=4, RR N=5)
module tb_rr_grant_encoder;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2;
    logic       ack0, ack1, ack2;
    logic [3:0] req0, req1;
    logic [4:0] req2;

    logic       v0, v1, v2;
    logic [1:0] i0, i1;
    logic [2:0] i2;
    logic [3:0] o0, o1;
    logic [4:0] o2;

    rr_grant_encoder #(.N(4), .IDX_W(2), .RR_MODE(0)) dut0 (
        .clk_in(clk), .rst_in(rst0), .req_in(req0), .ack_in(ack0),
        .gnt_valid_out(v0), .gnt_idx_out(i0), .gnt_onehot_out(o0)
    );
    rr_grant_encoder #(.N(4), .IDX_W(2), .RR_MODE(1)) dut1 (
        .clk_in(clk), .rst_in(rst1), .req_in(req1), .ack_in(ack1),
        .gnt_valid_out(v1), .gnt_idx_out(i1), .gnt_onehot_out(o1)
    );
    rr_grant_encoder #(.N(5), .IDX_W(3), .RR_MODE(1)) dut2 (
        .clk_in(clk), .rst_in(rst2), .req_in(req2), .ack_in(ack2),
        .gnt_valid_out(v2), .gnt_idx_out(i2), .gnt_onehot_out(o2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one grant slot per instance, pointer as a plain integer
    int m_valid[3];
    int m_idx[3];
    int m_ptr[3];

    function automatic int n_of(input int d);
        return (d == 2) ? 5 : 4;
    endfunction

    function automatic bit rr_of(input int d);
        return d != 0;
    endfunction

    // Circular scan starting at the pointer; fixed mode always starts at 0
    function automatic int winner(input int req, input int ptr, input int n, input bit rr);
        int start;
        start = rr ? ptr : 0;
        for (int k = 0; k < n; k++) begin
            if (req[(start + k) % n]) return (start + k) % n;
        end
        return 0;
    endfunction

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = 0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int r; bit a; bit rs;
            r  = (d == 0) ? int'(req0) : (d == 1) ? int'(req1) : int'(req2);
            a  = (d == 0) ? ack0 : (d == 1) ? ack1 : ack2;
            rs = (d == 0) ? rst0 : (d == 1) ? rst1 : rst2;
            if (rs) begin
                m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = 0;
            end else if (m_valid[d] != 0) begin
                if (a) begin
                    if (rr_of(d)) m_ptr[d] = (m_idx[d] + 1) % n_of(d);
                    m_valid[d] = 0;
                    m_idx[d]   = 0;
                end
            end else if (r != 0) begin
                m_valid[d] = 1;
                m_idx[d]   = winner(r, m_ptr[d], n_of(d), rr_of(d));
            end
        end
    end

    // Every-cycle compare against the model, just after the active edge
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            int av; int ai; int ao; int eo;
            av = (d == 0) ? int'(v0) : (d == 1) ? int'(v1) : int'(v2);
            ai = (d == 0) ? int'(i0) : (d == 1) ? int'(i1) : int'(i2);
            ao = (d == 0) ? int'(o0) : (d == 1) ? int'(o1) : int'(o2);
            eo = (m_valid[d] != 0) ? (1 << m_idx[d]) : 0;
            chk($sformatf("model_valid[%0d]", d), av, m_valid[d]);
            chk($sformatf("model_idx[%0d]", d), ai, m_idx[d]);
            chk($sformatf("model_onehot[%0d]", d), ao, eo);
            chk($sformatf("onehot_popcount[%0d]", d), $countones(ao), av);
            chk($sformatf("idx_in_range[%0d]", d), int'(ai < n_of(d)), 1);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst0 = 1; rst1 = 1; rst2 = 1;
        ack0 = 0; ack1 = 0; ack2 = 0;
        req0 = 0; req1 = 4'b1111; req2 = 0;

        // Reset held for 2 cycles with all requests up
        step(); step();
        chk("rst_valid", int'(v1), 0);
        chk("rst_idx", int'(i1), 0);
        chk("rst_onehot", int'(o1), 0);
        rst0 = 0; rst1 = 0; rst2 = 0;
        step();
        chk("post_rst_valid", int'(v1), 1);
        chk("post_rst_idx", int'(i1), 0);
        chk("post_rst_onehot", int'(o1), 4'b0001);

        // Round-robin rotation with all requests held
        begin
            int exp_seq[5] = '{1, 2, 3, 0, 1};
            for (int k = 0; k < 5; k++) begin
                ack1 = 1;
                step();
                chk("rr_bubble", int'(v1), 0);
                ack1 = 0;
                step();
                chk("rr_seq_valid", int'(v1), 1);
                chk($sformatf("rr_seq_idx%0d", k), int'(i1), exp_seq[k]);
            end
        end

        // Wrap: grant 2, then only low lines requested with ptr=3
        ack1 = 1; step(); ack1 = 0; step();
        chk("wrap_g2", int'(i1), 2);
        ack1 = 1; req1 = 4'b0011; step();
        chk("wrap_ack_release", int'(v1), 0);
        ack1 = 0; step();
        chk("wrap_g0", int'(i1), 0);
        chk("wrap_g0_onehot", int'(o1), 4'b0001);
        ack1 = 1; step(); ack1 = 0; step();
        chk("wrap_ptr1", int'(i1), 1);

        // Ack in IDLE with no requests leaves ptr alone (ptr=2 here)
        ack1 = 1; req1 = 4'b0000; step();
        step(); step();
        chk("idle_ack_valid", int'(v1), 0);
        ack1 = 0; req1 = 4'b1111; step();
        chk("idle_ack_ptr_kept", int'(i1), 2);
        ack1 = 1; req1 = 4'b1000; step(); ack1 = 0; step();
        chk("abort_g3", int'(i1), 3);
        rst1 = 1; req1 = 4'b1111; step();
        chk("abort_valid", int'(v1), 0);
        chk("abort_idx", int'(i1), 0);
        chk("abort_onehot", int'(o1), 0);
        rst1 = 0; step();
        chk("abort_ptr0", int'(i1), 0);
        ack1 = 1; req1 = 0; step(); ack1 = 0;

        // Fixed priority: grant frozen while held, bubble after ack
        req0 = 4'b1010; step();
        chk("fix_valid", int'(v0), 1);
        chk("fix_idx", int'(i0), 1);
        chk("fix_onehot", int'(o0), 4'b0010);
        req0 = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fix_hold_idx", int'(i0), 1);
            chk("fix_hold_onehot", int'(o0), 4'b0010);
        end
        ack0 = 1; step();
        chk("fix_release", int'(v0), 0);
        ack0 = 0; step();
        chk("fix_next_idx", int'(i0), 3);
        chk("fix_next_onehot", int'(o0), 4'b1000);
        ack0 = 1; req0 = 0; step(); ack0 = 0;

        // N=5: pointer wraps at 5, not at 8
        req2 = 5'b10001; step();
        chk("n5_g0", int'(i2), 0);
        ack2 = 1; step(); ack2 = 0; step();
        chk("n5_g4", int'(i2), 4);
        chk("n5_g4_onehot", int'(o2), 5'b10000);
        ack2 = 1; step(); ack2 = 0; step();
        chk("n5_wrap_g0", int'(i2), 0);
        ack2 = 1; req2 = 0; step(); ack2 = 0;

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- Parametrised successor to the fixed 4-to-2 one-hot encoder.
- Accepts N request lines, which may have any number of bits set, and selects one winner. Selection is fixed-priority or round-robin, chosen at elaboration.
- Registers the winner as a binary index plus a one-hot vector, and holds the grant until the requester acknowledges it.
- Used in front of shared resources in the core: memory port sharing, writeback arbitration.

Parameters:
- N, 4: number of request lines; N >= 2, any value, power of two not required.
- IDX_W, 2: grant index width; must equal max(1, clog2(N)).
- RR_MODE, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- req_in  input  N  request vector; any number of bits may be set.
- ack_in  input  1  the granted requester has finished; releases the grant.
- gnt_valid_out  output  1  a grant is currently held.
- gnt_idx_out  output  IDX_W  binary index of the granted line.
- gnt_onehot_out  output  N  one-hot form of gnt_idx_out; all zeros when not valid.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - state <= IDLE, ptr <= 0.
  - gnt_valid_out, gnt_idx_out and gnt_onehot_out <= 0.
  - Reset has priority over every other event, including a reset that arrives mid-grant.
- FSM states: IDLE, GRANT. All outputs are registered; none is driven combinationally from the inputs.
- In IDLE with req_in == 0:
  - Stay in IDLE; outputs remain 0.
- In IDLE with req_in != 0:
  - Compute the winner w combinationally.
  - Fixed mode: w = lowest set index.
  - Round-robin mode: w = lowest set index >= ptr; if there is none, w = lowest set index overall (wrap-around).
  - Next edge: state <= GRANT, gnt_valid_out <= 1, gnt_idx_out <= w, gnt_onehot_out <= (1 << w).
  - Latency from req_in to grant is 1 cycle.
- In GRANT with ack_in=0:
  - Outputs are frozen and ignore all req_in changes, including the granted bit dropping.
- In GRANT with ack_in=1, on the next edge:
  - state <= IDLE; all outputs <= 0.
  - Round-robin mode: ptr <= w+1, or 0 if w == N-1. Wrap is at N, not at 2^IDX_W.
  - Fixed mode: ptr is unused and stays 0.
- Throughput: at most one grant per 2 cycles. There is always one bubble cycle in IDLE after an ack; no back-to-back regrant.
- ack_in while in IDLE is ignored, and ptr does not change.
- Simultaneous events:
  - ack_in together with new requests in GRANT: only the release happens. The new arbitration occurs in the following IDLE cycle, using the updated ptr.
- Invariants:
  - gnt_onehot_out has exactly one bit set when gnt_valid_out=1, and is 0 otherwise.
  - gnt_idx_out < N at all times.
- Unused upper index codes never appear, even when N is not a power of two.

Decomposition:
- Shared package/header (core101 defs):
  - state localparams: IDLE=1'b0, GRANT=1'b1.
  - a clog2 helper function for IDX_W.
- Sub-module prio_enc #(N, IDX_W):
  - Combinational lowest-set-bit finder; outputs idx and any_valid.
  - Generalises the old encoder: the lowest set bit wins instead of defaulting to 0 on invalid input.
- In round-robin mode rr_grant_encoder instantiates prio_enc twice:
  - once on req_in masked to bits >= ptr;
  - once on req_in unmasked.
  - If the masked instance reports any_valid, its idx is used; otherwise the unmasked idx is used.

Test Plan:
1. Reset: hold rst_in=1 for 2 cycles with req_in=4'b1111 -> gnt_valid_out=0, gnt_idx_out=0, gnt_onehot_out=0; after release, grant idx 0 appears 1 cycle later.
2. Fixed mode (RR_MODE=0), N=4:
   - req_in=4'b1010 -> next cycle valid=1, idx=1, onehot=4'b0010.
   - Change req_in to 4'b1000 for 3 cycles -> outputs unchanged.
   - ack_in=1 -> valid=0 next cycle; then idx=3 after one bubble.
3. Round-robin, N=4: req_in=4'b1111 held, ack issued one cycle after each grant -> idx sequence 0,1,2,3,0,1 with one idle cycle between grants.
4. Round-robin wrap, N=4: grant idx 2 and ack (ptr=3), then req_in=4'b0011 -> grant idx 0; ack -> ptr=1.
5. Ignore and abort:
   - ack_in=1 in IDLE with req_in=0 -> no state change, ptr unchanged.
   - rst_in=1 during GRANT idx 3 -> next cycle all outputs 0, ptr=0.
6. Non-power-of-two, N=5, IDX_W=3, round-robin: req_in=5'b10001, grant and ack idx 0 (ptr=1) -> next grant idx 4; ack -> ptr=0 (not 5); next grant idx 0.
